// File: rtl/serial_frame_pkg.sv
// Shared types and line levels for the bit-serial frame receiver.
package serial_frame_pkg;
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } state_e;

  localparam logic STOP_BIT  = 1'b1;
  localparam logic START_BIT = 1'b0;
endpackage

// File: rtl/frame_shift_in.sv
// LSB-first shift register: new bits enter at the MSB, so after W loads
// the first bit received sits at bit 0.
module frame_shift_in #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         clr_n,
  input  logic         en_i,
  input  logic         bit_i,
  output logic [W-1:0] data_o
);
  logic [W-1:0] sh_q, sh_d;

  generate
    if (W == 1) begin : g_one
      assign sh_d = bit_i;
    end else begin : g_many
      assign sh_d = {bit_i, sh_q[W-1:1]};
    end
  endgenerate

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n)    sh_q <= '0;
    else if (en_i) sh_q <= sh_d;
  end

  assign data_o = sh_q;
endmodule

// File: rtl/serial_frame_rx.sv
// Serial start/data/parity/stop receiver with a one-word valid/ready
// output register, parity/framing flags and a sticky overrun flag.
module serial_frame_rx
  import serial_frame_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter bit PARITY_EN = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              d,
  input  logic              bit_en,
  output logic [DATA_W-1:0] q_data,
  output logic              q_valid,
  input  logic              q_ready,
  output logic              parity_err,
  output logic              frame_err,
  output logic              overrun
);
  localparam int CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);

  state_e            st_q, st_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              par_q, par_d;
  logic              shift_en, done, ferr_d;
  logic [DATA_W-1:0] word;
  logic              perr_calc, load;

  logic [DATA_W-1:0] qdata_q;
  logic              qvalid_q, qvalid_d;
  logic              perr_q, ferr_q, ovr_q, ovr_d;

  frame_shift_in #(.W(DATA_W)) u_shift (
    .clk    (clk),
    .clr_n  (reset),
    .en_i   (shift_en),
    .bit_i  (d),
    .data_o (word)
  );

  always_comb begin
    st_d     = st_q;
    cnt_d    = cnt_q;
    par_d    = par_q;
    shift_en = 1'b0;
    done     = 1'b0;
    ferr_d   = 1'b0;
    if (bit_en) begin
      case (st_q)
        ST_IDLE: begin
          if (d == START_BIT) begin
            st_d  = ST_DATA;
            cnt_d = '0;
          end
        end
        ST_DATA: begin
          shift_en = 1'b1;
          // Counter holds at LAST on exit; IDLE re-clears it on the next start.
          if (cnt_q == LAST) st_d = PARITY_EN ? ST_PARITY : ST_STOP;
          else               cnt_d = cnt_q + CW'(1);
        end
        ST_PARITY: begin
          par_d = d;
          st_d  = ST_STOP;
        end
        ST_STOP: begin
          done   = (d == STOP_BIT);
          ferr_d = (d != STOP_BIT);
          st_d   = ST_IDLE;
        end
        default: st_d = ST_IDLE;
      endcase
    end
  end

  assign perr_calc = PARITY_EN ? (^word ^ par_q) : 1'b0;

  // A finished word lands only if the slot is empty or being drained now.
  assign load     = done & (~qvalid_q | q_ready);
  assign ovr_d    = ovr_q | (done & qvalid_q & ~q_ready);
  assign qvalid_d = load ? 1'b1 : ((qvalid_q & q_ready) ? 1'b0 : qvalid_q);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st_q     <= ST_IDLE;
      cnt_q    <= '0;
      par_q    <= 1'b0;
      qdata_q  <= '0;
      qvalid_q <= 1'b0;
      perr_q   <= 1'b0;
      ferr_q   <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      st_q     <= st_d;
      cnt_q    <= cnt_d;
      par_q    <= par_d;
      qvalid_q <= qvalid_d;
      ferr_q   <= ferr_d;
      ovr_q    <= ovr_d;
      if (load) begin
        qdata_q <= word;
        perr_q  <= perr_calc;
      end
    end
  end

  assign q_data     = qdata_q;
  assign q_valid    = qvalid_q;
  assign parity_err = perr_q;
  assign frame_err  = ferr_q;
  assign overrun    = ovr_q;
endmodule

// File: tb/tb_serial_frame_rx.sv
// Directed bench for serial_frame_rx: stimulus pushes expected words into a
// queue, a negedge monitor pops and compares on every accepted transfer.
module tb_serial_frame_rx;
  logic       clk = 1'b0;
  logic       reset;
  logic       d;
  logic       bit_en;
  logic [7:0] q_data;
  logic       q_valid;
  logic       q_ready;
  logic       parity_err;
  logic       frame_err;
  logic       overrun;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [7:0] data;
    logic       perr;
  } exp_t;
  exp_t exp_q[$];

  serial_frame_rx #(.DATA_W(8), .PARITY_EN(1'b1)) dut (
    .clk        (clk),
    .reset      (reset),
    .d          (d),
    .bit_en     (bit_en),
    .q_data     (q_data),
    .q_valid    (q_valid),
    .q_ready    (q_ready),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Monitor: each negedge with valid&ready is exactly one transfer at the next edge.
  always @(negedge clk) begin
    if (reset === 1'b1 && q_valid === 1'b1 && q_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_word: got %0h expected none", q_data);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("sb_data", {24'd0, q_data}, {24'd0, e.data});
        chk("sb_perr", {31'd0, parity_err}, {31'd0, e.perr});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b, input int gap);
    bit_en = 1'b1;
    d      = b;
    tick();
    bit_en = 1'b0;
    d      = 1'b1;
    repeat (gap) tick();
  endtask

  // Full frame; rdy_on_stop raises q_ready together with the stop strobe.
  task automatic send_frame(input logic [7:0] data, input logic par, input logic stop,
                            input int gap, input bit rdy_on_stop);
    send_bit(1'b0, gap);
    for (int i = 0; i < 8; i++) send_bit(data[i], gap);
    send_bit(par, gap);
    if (rdy_on_stop) q_ready = 1'b1;
    send_bit(stop, gap);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset   = 1'b0;
    d       = 1'b1;
    bit_en  = 1'b0;
    q_ready = 1'b1;
    tick();
    tick();
    chk("rst_valid", {31'd0, q_valid}, 32'd0);
    chk("rst_data", {24'd0, q_data}, 32'd0);
    chk("rst_flags", {29'd0, parity_err, frame_err, overrun}, 32'd0);
    reset = 1'b1;
    tick();

    // Basic frame
    exp_q.push_back('{data: 8'hA5, perr: 1'b0});
    send_frame(8'hA5, 1'b0, 1'b1, 0, 1'b0);
    chk("basic_valid", {31'd0, q_valid}, 32'd1);
    tick();
    chk("basic_valid_drop", {31'd0, q_valid}, 32'd0);

    // Parity error held with q_ready low
    q_ready = 1'b0;
    send_frame(8'h01, 1'b0, 1'b1, 0, 1'b0);
    chk("perr_valid", {31'd0, q_valid}, 32'd1);
    chk("perr_flag", {31'd0, parity_err}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("perr_hold", {24'd0, q_data}, 32'h01);
    end
    exp_q.push_back('{data: 8'h01, perr: 1'b1});
    q_ready = 1'b1;
    tick();
    chk("perr_drain", {31'd0, q_valid}, 32'd0);

    // Framing error, then a good frame right behind it
    send_frame(8'h3C, 1'b0, 1'b0, 0, 1'b0);
    chk("ferr_pulse", {31'd0, frame_err}, 32'd1);
    chk("ferr_novalid", {31'd0, q_valid}, 32'd0);
    exp_q.push_back('{data: 8'h5A, perr: 1'b0});
    send_frame(8'h5A, 1'b0, 1'b1, 0, 1'b0);
    chk("ferr_pulse_end", {31'd0, frame_err}, 32'd0);
    chk("ferr_recover", {31'd0, q_valid}, 32'd1);
    tick();

    // Overrun: second word dropped
    q_ready = 1'b0;
    send_frame(8'h11, 1'b0, 1'b1, 0, 1'b0);
    send_frame(8'h22, 1'b0, 1'b1, 0, 1'b0);
    chk("ovr_data", {24'd0, q_data}, 32'h11);
    chk("ovr_flag", {31'd0, overrun}, 32'd1);
    exp_q.push_back('{data: 8'h11, perr: 1'b0});
    q_ready = 1'b1;
    tick();
    chk("ovr_drain", {31'd0, q_valid}, 32'd0);
    chk("ovr_sticky", {31'd0, overrun}, 32'd1);

    do_reset();
    chk("ovr_cleared", {31'd0, overrun}, 32'd0);
    tick();

    // Load and accept in the same cycle
    q_ready = 1'b0;
    send_frame(8'h55, 1'b0, 1'b1, 0, 1'b0);
    exp_q.push_back('{data: 8'h55, perr: 1'b0});
    exp_q.push_back('{data: 8'hAA, perr: 1'b0});
    send_frame(8'hAA, 1'b0, 1'b1, 0, 1'b1);
    chk("sim_data", {24'd0, q_data}, 32'hAA);
    chk("sim_valid", {31'd0, q_valid}, 32'd1);
    chk("sim_novr", {31'd0, overrun}, 32'd0);
    tick();
    chk("sim_drain", {31'd0, q_valid}, 32'd0);

    // Gapped strobes, then reset mid-frame with a word still held
    q_ready = 1'b0;
    send_frame(8'hF0, 1'b0, 1'b1, 3, 1'b0);
    chk("gap_data", {24'd0, q_data}, 32'hF0);
    chk("gap_valid", {31'd0, q_valid}, 32'd1);
    send_bit(1'b0, 0);
    for (int i = 0; i < 4; i++) send_bit(1'b1, 0);
    reset = 1'b0;
    #1;
    chk("midrst_valid", {31'd0, q_valid}, 32'd0);
    chk("midrst_data", {24'd0, q_data}, 32'd0);
    chk("midrst_flags", {29'd0, parity_err, frame_err, overrun}, 32'd0);
    tick();
    reset   = 1'b1;
    q_ready = 1'b1;
    tick();
    exp_q.push_back('{data: 8'h0F, perr: 1'b0});
    send_frame(8'h0F, 1'b0, 1'b1, 0, 1'b0);
    chk("fresh_valid", {31'd0, q_valid}, 32'd1);
    tick();
    tick();

    chk("sb_empty", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
